// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// Instruction fetch stage: owns the PC, requests words from instruction memory and
// feeds the decoder through an IF/ID register backed by a one-entry skid buffer.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic [5:0]  funct,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic        valid
);

   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] skid_instr;
   logic [31:0] skid_pc;
   logic        load;

   // IF/ID may take a new word when it is empty or the decoder is draining it.
   assign load = !valid || !stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         pc         <= RESET_PC & ALIGN_MASK;
         instr      <= '0;
         pc_out     <= '0;
         valid      <= 1'b0;
         skid_instr <= '0;
         skid_pc    <= '0;
      end else if (redirect) begin
         // Flush wins over stall and over any word returning this cycle.
         state      <= FETCH;
         pc         <= redirect_pc & ALIGN_MASK;
         instr      <= '0;
         valid      <= 1'b0;
         skid_instr <= '0;
         skid_pc    <= '0;
      end else begin
         unique case (state)
            IDLE: state <= FETCH;
            FETCH: begin
               if (imem_ready) begin
                  pc <= pc + 32'd4;
                  if (load) begin
                     instr  <= imem_rdata;
                     pc_out <= pc;
                     valid  <= 1'b1;
                  end else begin
                     skid_instr <= imem_rdata;
                     skid_pc    <= pc;
                     state      <= HOLD;
                  end
               end else if (!stall) begin
                  valid <= 1'b0;
               end
            end
            HOLD: begin
               if (!stall) begin
                  instr  <= skid_instr;
                  pc_out <= skid_pc;
                  valid  <= 1'b1;
                  state  <= FETCH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Request is a pure state decode so imem_ready never loops back into it.
   assign imem_req  = (state == FETCH);
   assign imem_addr = pc;
   assign op        = instr[31:26];
   assign funct     = instr[5:0];
   assign pc_plus4  = pc_out + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for fetch_stage: accepted fetches are queued as the
// program-order PCs the decoder must see, and popped as the decoder consumes them.
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        imem_ready = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] instr;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic        valid;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   logic [31:0] fetch_exp = RST_PC;
   logic        model_idle = 1'b1;
   logic        chk_zero = 1'b1;
   logic        chk_pc0 = 1'b1;
   logic        m_req;
   logic [31:0] m_pc;
   logic [31:0] m_w;

   fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .instr(instr), .op(op), .funct(funct),
      .pc_out(pc_out), .pc_plus4(pc_plus4), .valid(valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0C00_0021;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_inputs(input logic s, input logic r, input logic rd, input logic [31:0] rpc);
      stall       = s;
      imem_ready  = r;
      redirect    = rd;
      redirect_pc = rpc;
      imem_rdata  = r ? mem_word(imem_addr) : $urandom;
   endtask

   task automatic drive(input logic s, input logic r, input logic rd, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      set_inputs(s, r, rd, rpc);
   endtask

   // Monitor: check the outputs left by the last edge, then advance the model
   // across the coming edge using the inputs now applied.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         fetch_exp  = RST_PC;
         model_idle = 1'b1;
         chk_zero   = 1'b1;
         chk_pc0    = 1'b1;
      end else begin
         m_req = !model_idle && (exp_q.size() < 2);
         chk("imem_req", 32'(imem_req), 32'(m_req));
         if (m_req || model_idle) chk("imem_addr", imem_addr, fetch_exp);
         if (exp_q.size() > 0) begin
            m_pc = exp_q[0];
            m_w  = mem_word(m_pc);
            chk("valid", 32'(valid), 32'd1);
            chk("pc_out", pc_out, m_pc);
            chk("instr", instr, m_w);
            chk("op", 32'(op), 32'(m_w[31:26]));
            chk("funct", 32'(funct), 32'(m_w[5:0]));
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
         end else begin
            chk("valid_empty", 32'(valid), 32'd0);
         end
         if (chk_zero) begin
            chk("instr_cleared", instr, 32'd0);
            chk_zero = 1'b0;
         end
         if (chk_pc0) begin
            chk("pc_out_reset", pc_out, 32'd0);
            chk_pc0 = 1'b0;
         end
         if (redirect) begin
            exp_q.delete();
            fetch_exp  = redirect_pc & 32'hFFFF_FFFC;
            model_idle = 1'b0;
            chk_zero   = 1'b1;
         end else begin
            if (exp_q.size() > 0 && !stall) void'(exp_q.pop_front());
            if (m_req && imem_ready) begin
               exp_q.push_back(fetch_exp);
               fetch_exp = fetch_exp + 32'd4;
            end
            model_idle = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      set_inputs(1'b0, 1'b1, 1'b0, 32'd0);
      // edge 2 captures 0x100, then three wait states at 0x104
      drive(1'b0, 1'b1, 1'b0, 32'd0);
      repeat (3) drive(1'b0, 1'b0, 1'b0, 32'd0);
      repeat (6) drive(1'b0, 1'b1, 1'b0, 32'd0);

      // stall with skid, then release
      repeat (4) drive(1'b1, 1'b1, 1'b0, 32'd0);
      repeat (4) drive(1'b0, 1'b1, 1'b0, 32'd0);

      // redirect from HOLD, together with stall and ready
      repeat (3) drive(1'b1, 1'b1, 1'b0, 32'd0);
      drive(1'b1, 1'b1, 1'b1, 32'h0000_2003);
      repeat (5) drive(1'b0, 1'b1, 1'b0, 32'd0);

      // wrap across the top of the address space
      drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
      repeat (5) drive(1'b0, 1'b1, 1'b0, 32'd0);
      drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9);
      repeat (3) drive(1'b1, 1'b1, 1'b0, 32'd0);
      repeat (4) drive(1'b0, 1'b1, 1'b0, 32'd0);

      repeat (3000) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : $urandom;
         drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0,
               $urandom_range(0, 19) == 0, rpc);
      end

      // async reset while a request is outstanding and IF/ID is live
      repeat (3) drive(1'b0, 1'b1, 1'b0, 32'd0);
      repeat (2) drive(1'b1, 1'b0, 1'b0, 32'd0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("async_valid", 32'(valid), 32'd0);
      chk("async_instr", instr, 32'd0);
      chk("async_pc_out", pc_out, 32'd0);
      chk("async_req", 32'(imem_req), 32'd0);
      chk("async_addr", imem_addr, RST_PC);
      imem_ready = 1'b1;
      imem_rdata = $urandom;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready_valid", 32'(valid), 32'd0);
      chk("reset_ready_addr", imem_addr, RST_PC);
      rst = 1'b0;
      set_inputs(1'b0, 1'b1, 1'b0, 32'd0);
      repeat (8) drive(1'b0, 1'b1, 1'b0, 32'd0);
      repeat (2) drive(1'b0, 1'b0, 1'b0, 32'd0);

      @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
